r16_bank_rdr: RTL

R16_BANK_RDR -- requirements
Module: r16_bank_rdr

---
 rtl/r16_bank_rdr.sv | 139 +++++++++++++
 1 files changed

// File: rtl/r16_bank_rdr.sv
// Two-bank sample store feeding a ping/pong radix-16 group assembler with backpressure.
// Optional lane-order checker compiled in with `define R16_BANK_RDR_LANE_CHK_EN.
module r16_bank_rdr #(
  parameter int DW      = 32,
  parameter int A_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_vld,
  input  logic                 BN_in,
  input  logic [A_WIDTH-1:0]   MA_in,
  input  logic [3:0]           lane_in,
  input  logic                 wr_en,
  input  logic                 wr_BN,
  input  logic [A_WIDTH-1:0]   wr_MA,
  input  logic [DW-1:0]        wr_data,
  output logic                 rd_stall,
  output logic [16*DW-1:0]     grp_data,
  output logic                 grp_vld,
  input  logic                 grp_rdy,
  output logic                 lane_err
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_st_e;

  buf_st_e       r_st     [2];
  buf_st_e       w_st_nxt [2];
  logic          r_wr_sel;
  logic          r_rd_sel;

  logic [DW-1:0] r_bank0 [2**A_WIDTH];
  logic [DW-1:0] r_bank1 [2**A_WIDTH];

  logic [DW-1:0] r_rdata_p0;
  logic [3:0]    r_lane_p0;
  logic          r_vld_p0;

  logic [DW-1:0] r_buf [2][16];

  logic          w_cap_last;
  logic          w_tgt;
  logic          w_rel;
  logic          w_buf_stall;
  logic          w_wr_conf;
  logic          w_rd_acc;

  // A request accepted now lands in the buffer two edges later, so its target
  // is the other buffer whenever a lane-15 capture is already in flight.
  assign w_cap_last  = r_vld_p0 && (r_lane_p0 == 4'd15);
  assign w_tgt       = w_cap_last ? ~r_wr_sel : r_wr_sel;
  assign grp_vld     = (r_st[r_rd_sel] == BUF_FULL);
  assign w_rel       = grp_vld && grp_rdy;
  assign w_buf_stall = (r_st[w_tgt] == BUF_FULL) && !(w_rel && (r_rd_sel == w_tgt));
  assign w_wr_conf   = wr_en && rd_vld && (wr_BN == BN_in);
  assign rd_stall    = !rst && (w_buf_stall || w_wr_conf);
  assign w_rd_acc    = rd_vld && !rd_stall && !rst;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_st_nxt[b] = r_st[b];
      if (w_rel && (r_rd_sel == 1'(b)))
        w_st_nxt[b] = BUF_EMPTY;
      if (r_vld_p0 && (r_wr_sel == 1'(b)))
        w_st_nxt[b] = (r_lane_p0 == 4'd15) ? BUF_FULL : BUF_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st[0]  <= BUF_EMPTY;
      r_st[1]  <= BUF_EMPTY;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_st[0]  <= w_st_nxt[0];
      r_st[1]  <= w_st_nxt[1];
      if (w_cap_last)
        r_wr_sel <= ~r_wr_sel;
      if (w_rel)
        r_rd_sel <= ~r_rd_sel;
      r_vld_p0 <= w_rd_acc;
    end
  end

  // Bank write port; a same-bank read is stalled, so each bank sees one access.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_BN)
      r_bank0[wr_MA] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_BN)
      r_bank1[wr_MA] <= wr_data;
  end

  // Stage p0: bank read data and its lane index
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_rdata_p0 <= BN_in ? r_bank1[MA_in] : r_bank0[MA_in];
      r_lane_p0  <= lane_in;
    end
  end

  // Stage p1: lane capture into the filling buffer
  always_ff @(posedge clk) begin
    if (r_vld_p0)
      r_buf[r_wr_sel][r_lane_p0] <= r_rdata_p0;
  end

  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign grp_data[k*DW +: DW] = r_buf[r_rd_sel][k];
  end

`ifdef R16_BANK_RDR_LANE_CHK_EN
  logic [3:0] r_exp_lane;
  logic       r_lane_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_lane <= 4'd0;
      r_lane_err <= 1'b0;
    end else if (w_rd_acc) begin
      r_exp_lane <= r_exp_lane + 4'd1;
      if (lane_in != r_exp_lane)
        r_lane_err <= 1'b1;
    end
  end

  assign lane_err = r_lane_err;
`else
  assign lane_err = 1'b0;
`endif

endmodule
